// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame format and the receiver state encoding.
// The transmitter uses the same frame constants.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int PARITY_EVEN = 1;
  localparam int STOP_BITS   = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] h);
    return (h[0] & h[1]) | (h[1] & h[2]) | (h[0] & h[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a 3-sample majority filter.
// Everything resets to 1 so an idle (high) line looks quiet from reset.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic rx_ce,
  input  logic rxd,
  output logic rxd_s,
  output logic maj
);

  logic       meta;
  logic       sync;
  logic [2:0] hist;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= rxd;
      sync <= meta;
    end
  end

  // History only moves on oversample ticks so the filter spans three ticks.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        hist <= 3'b111;
    else if (rx_ce) hist <= {hist[1:0], sync};
  end

  assign rxd_s = sync;
  assign maj   = maj3(hist);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits LSB first, parity, 1 stop bit, oversampled by RX_CE.
// Received bytes are held under a RX_RDY/RX_ACK handshake.
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample
// START     | confirming the start bit at its centre
// DATA      | sampling the 8 data bits
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, frame completes at its centre
// WAIT_IDLE | stop bit was low; wait for the line to go high again
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_CE,
  input  logic       RXD,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_RDY,
  output logic       PAR_ERR,
  output logic       FRM_ERR,
  output logic       OVR_ERR,
  output logic       RX_BUSY
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVS - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_EVEN == 0);

  rx_state_t            state, state_nxt;
  logic                 rxd_s;
  logic                 maj;
  logic [CW-1:0]        smp_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 at_mid;
  logic                 at_end;
  logic                 frame_done;

  uart_rx_sync u_sync (
    .CLK   (CLK),
    .RST   (RST),
    .rx_ce (RX_CE),
    .rxd   (RXD),
    .rxd_s (rxd_s),
    .maj   (maj)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (RX_CE) begin
      case (state)
        IDLE:      if (!rxd_s) state_nxt = START;
        START:     if (at_mid) state_nxt = maj ? IDLE : DATA;
        DATA:      if (at_end && bit_cnt == LAST_BIT) state_nxt = PARITY;
        PARITY:    if (at_end) state_nxt = STOP;
        STOP:      if (at_end) state_nxt = maj ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (rxd_s) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    RX_BUSY    = (state != IDLE);
    at_mid     = (smp_cnt == CNT_MID);
    at_end     = (smp_cnt == CNT_END);
    frame_done = RX_CE && (state == STOP) && at_end;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      smp_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (RX_CE) begin
      case (state)
        IDLE: smp_cnt <= '0;
        START: begin
          smp_cnt <= at_mid ? '0 : smp_cnt + 1'b1;
          if (at_mid) bit_cnt <= '0;
        end
        DATA: begin
          if (at_end) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            smp_cnt <= '0;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (at_end) par_bit <= maj;
          smp_cnt <= at_end ? '0 : smp_cnt + 1'b1;
        end
        STOP:    smp_cnt <= at_end ? '0 : smp_cnt + 1'b1;
        default: smp_cnt <= '0;
      endcase
    end
  end

  // Completion beats a same-cycle acknowledge: the new byte stays presented.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RX_DATA <= 8'h00;
      RX_RDY  <= 1'b0;
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      OVR_ERR <= 1'b0;
    end else if (frame_done) begin
      RX_DATA <= shreg;
      PAR_ERR <= (par_bit != (^shreg ^ PAR_ODD));
      FRM_ERR <= !maj;
      RX_RDY  <= 1'b1;
      if (RX_RDY && !RX_ACK)     OVR_ERR <= 1'b1;
      else if (RX_RDY && RX_ACK) OVR_ERR <= 1'b0;
    end else if (RX_ACK && RX_RDY) begin
      RX_RDY  <= 1'b0;
      OVR_ERR <= 1'b0;
    end
  end

endmodule
